// File: rtl/uart_rx_os.sv
// Oversampling UART receiver.
// The serial line is synchronised, sampled OVERSAMPLE times per bit and each
// bit is resolved by a 3-sample majority vote around the bit centre. Received
// words and their error flags go to the consumer over a valid/ready handshake.
// A frame that completes while the previous word is still unread is dropped,
// and a one-cycle overrun pulse is raised.
module uart_rx_os #(
    parameter int CLK_RATE_MHz = 100,
    parameter int BAUDRATE     = 9600,
    parameter int DATA_WIDTH   = 8,
    parameter int OVERSAMPLE   = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_en,
    input  logic                  in_data,
    input  logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data_reg,
    output logic                  out_valid_reg,
    output logic                  out_parity_err_reg,
    output logic                  out_frame_err_reg,
    output logic                  out_break_reg,
    output logic                  out_overrun_reg,
    output logic                  out_busy
);

    // Clocks per oversample tick.
    localparam int TICK_M = (CLK_RATE_MHz * 1000000) / (BAUDRATE * OVERSAMPLE);
    localparam int TICK_W = (TICK_M > 1) ? $clog2(TICK_M) : 1;
    localparam int SMP_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_WIDTH);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_M - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [SMP_W-1:0]  SMP_V0    = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0]  SMP_V1    = SMP_W'(OVERSAMPLE / 2);
    localparam logic [SMP_W-1:0]  SMP_VOTE  = SMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SMP_W-1:0]  SMP_LAST  = SMP_W'(OVERSAMPLE - 1);
    localparam logic [SMP_W-1:0]  SMP_ONE   = SMP_W'(1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    // Refuse to elaborate with a clock too slow for the requested line rate
    // or with an unsupported frame format.
    if (TICK_M < 2) begin : g_bad_tick
        $error("uart_rx_os: TICK_M must be at least 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("uart_rx_os: DATA_WIDTH must be 5..9");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_os: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_os: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    // Parity mismatch of a received word against its parity bit.
    function automatic logic parity_err_f(input logic [DATA_WIDTH-1:0] d, input logic b);
        logic p;
        p = (^d) ^ b;
        if (PARITY == 2) begin
            return ~p;
        end else begin
            return p;
        end
    endfunction

    // Majority of three samples.
    function automatic logic majority3_f(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t                  state_q, state_d;
    logic [1:0]              sync_q, sync_d;
    logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic [SMP_W-1:0]        smp_q, smp_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]              vote_q, vote_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_err_q, par_err_d;
    logic                    frame_err_q, frame_err_d;

    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    perr_out_q, perr_out_d;
    logic                    ferr_out_q, ferr_out_d;
    logic                    brk_out_q, brk_out_d;
    logic                    ovr_q, ovr_d;

    logic                    rx_s;
    logic                    running_s;
    logic                    tick_s;
    logic                    vote_pt_s;
    logic                    bit_end_s;
    logic                    bit_s;
    logic                    frame_err_now_s;
    logic                    complete_s;

    assign rx_s            = sync_q[1];
    assign running_s       = (state_q != S_IDLE) && (state_q != S_WAIT_HIGH);
    assign tick_s          = running_s && (tick_cnt_q == TICK_LAST);
    assign vote_pt_s       = tick_s && (smp_q == SMP_VOTE);
    assign bit_end_s       = tick_s && (smp_q == SMP_LAST);
    assign bit_s           = majority3_f(vote_q[0], vote_q[1], rx_s);
    assign frame_err_now_s = frame_err_q | ~bit_s;

    // Frame sequencing: next state, data shift register and error accumulation.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        complete_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d     = S_START;
                    bit_cnt_d   = {BIT_W{1'b0}};
                    par_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (vote_pt_s && bit_s) begin
                    state_d = S_IDLE;          // glitch, not a real start bit
                end else if (bit_end_s) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (vote_pt_s) begin
                    shift_d = {bit_s, shift_q[DATA_WIDTH-1:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (bit_end_s) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = {BIT_W{1'b0}};
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            S_PARITY: begin
                if (vote_pt_s) begin
                    par_err_d = parity_err_f(shift_q, bit_s);
                end else begin
                    par_err_d = par_err_q;
                end
                if (bit_end_s) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (vote_pt_s) begin
                    frame_err_d = frame_err_now_s;
                    if (bit_cnt_q == STOP_LAST) begin
                        // Finish at the centre of the last stop bit so a
                        // back-to-back start edge is not missed.
                        complete_s = 1'b1;
                        state_d    = frame_err_now_s ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        state_d = S_STOP;
                    end
                end else if (bit_end_s) begin
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_HIGH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Tick, sample-position and vote-sample bookkeeping.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        smp_d      = smp_q;
        vote_d     = vote_q;
        if (!running_s || state_d == S_IDLE || state_d == S_WAIT_HIGH) begin
            tick_cnt_d = {TICK_W{1'b0}};
            smp_d      = {SMP_W{1'b0}};
        end else if (tick_s) begin
            tick_cnt_d = {TICK_W{1'b0}};
            smp_d      = (smp_q == SMP_LAST) ? {SMP_W{1'b0}} : (smp_q + SMP_ONE);
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
        end
        if (tick_s && smp_q == SMP_V0) begin
            vote_d[0] = rx_s;
        end else if (tick_s && smp_q == SMP_V1) begin
            vote_d[1] = rx_s;
        end else begin
            vote_d = vote_q;
        end
    end

    // Consumer handshake: load on completion, or flag an overrun when full.
    always_comb begin
        valid_d    = valid_q;
        data_out_d = data_out_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        brk_out_d  = brk_out_q;
        ovr_d      = 1'b0;
        if (valid_q && in_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (complete_s) begin
            if (!valid_q || in_ready) begin
                valid_d    = 1'b1;
                data_out_d = shift_q;
                perr_out_d = par_err_q;
                ferr_out_d = frame_err_now_s;
                brk_out_d  = frame_err_now_s && (shift_q == {DATA_WIDTH{1'b0}});
            end else begin
                ovr_d = 1'b1;
            end
        end else begin
            ovr_d = 1'b0;
        end
    end

    // State and output registers; in_en low freezes everything.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= S_IDLE;
            sync_q      <= 2'b11;
            tick_cnt_q  <= {TICK_W{1'b0}};
            smp_q       <= {SMP_W{1'b0}};
            bit_cnt_q   <= {BIT_W{1'b0}};
            vote_q      <= 2'b00;
            shift_q     <= {DATA_WIDTH{1'b0}};
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            valid_q     <= 1'b0;
            data_out_q  <= {DATA_WIDTH{1'b0}};
            perr_out_q  <= 1'b0;
            ferr_out_q  <= 1'b0;
            brk_out_q   <= 1'b0;
            ovr_q       <= 1'b0;
        end else if (in_en) begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            tick_cnt_q  <= tick_cnt_d;
            smp_q       <= smp_d;
            bit_cnt_q   <= bit_cnt_d;
            vote_q      <= vote_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            valid_q     <= valid_d;
            data_out_q  <= data_out_d;
            perr_out_q  <= perr_out_d;
            ferr_out_q  <= ferr_out_d;
            brk_out_q   <= brk_out_d;
            ovr_q       <= ovr_d;
        end
    end

    // Two-flop synchroniser input for the asynchronous line.
    always_comb begin
        sync_d = {sync_q[0], in_data};
    end

    assign out_data_reg       = data_out_q;
    assign out_valid_reg      = valid_q;
    assign out_parity_err_reg = perr_out_q;
    assign out_frame_err_reg  = ferr_out_q;
    assign out_break_reg      = brk_out_q;
    assign out_overrun_reg    = ovr_q;
    assign out_busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed testbench for uart_rx_os at 16 MHz / 500 kbaud / x16 (32 clk per bit).
// Four receivers: 8N1, 8E1, 8O1 (sharing one line) and 8N2.
module tb_uart_rx_os;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic ready;
    logic line_a;
    logic line_p;
    logic line_s2;

    logic [7:0] dout  [4];
    logic       valid [4];
    logic       perr  [4];
    logic       ferr  [4];
    logic       brk   [4];
    logic       ovr   [4];
    logic       busy  [4];

    int vcnt  [4];
    int ocnt  [4];
    logic [7:0] cap_d  [4];
    logic       cap_pe [4];
    logic       cap_fe [4];
    logic       cap_bk [4];

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    uart_rx_os #(.CLK_RATE_MHz(16), .BAUDRATE(500000), .DATA_WIDTH(8), .OVERSAMPLE(16),
                 .PARITY(0), .STOP_BITS(1)) dut_a (
        .in_clk(clk), .in_rst(rst), .in_en(en), .in_data(line_a), .in_ready(ready),
        .out_data_reg(dout[0]), .out_valid_reg(valid[0]), .out_parity_err_reg(perr[0]),
        .out_frame_err_reg(ferr[0]), .out_break_reg(brk[0]), .out_overrun_reg(ovr[0]),
        .out_busy(busy[0]));

    uart_rx_os #(.CLK_RATE_MHz(16), .BAUDRATE(500000), .DATA_WIDTH(8), .OVERSAMPLE(16),
                 .PARITY(1), .STOP_BITS(1)) dut_pe (
        .in_clk(clk), .in_rst(rst), .in_en(en), .in_data(line_p), .in_ready(ready),
        .out_data_reg(dout[1]), .out_valid_reg(valid[1]), .out_parity_err_reg(perr[1]),
        .out_frame_err_reg(ferr[1]), .out_break_reg(brk[1]), .out_overrun_reg(ovr[1]),
        .out_busy(busy[1]));

    uart_rx_os #(.CLK_RATE_MHz(16), .BAUDRATE(500000), .DATA_WIDTH(8), .OVERSAMPLE(16),
                 .PARITY(2), .STOP_BITS(1)) dut_po (
        .in_clk(clk), .in_rst(rst), .in_en(en), .in_data(line_p), .in_ready(ready),
        .out_data_reg(dout[2]), .out_valid_reg(valid[2]), .out_parity_err_reg(perr[2]),
        .out_frame_err_reg(ferr[2]), .out_break_reg(brk[2]), .out_overrun_reg(ovr[2]),
        .out_busy(busy[2]));

    uart_rx_os #(.CLK_RATE_MHz(16), .BAUDRATE(500000), .DATA_WIDTH(8), .OVERSAMPLE(16),
                 .PARITY(0), .STOP_BITS(2)) dut_s2 (
        .in_clk(clk), .in_rst(rst), .in_en(en), .in_data(line_s2), .in_ready(ready),
        .out_data_reg(dout[3]), .out_valid_reg(valid[3]), .out_parity_err_reg(perr[3]),
        .out_frame_err_reg(ferr[3]), .out_break_reg(brk[3]), .out_overrun_reg(ovr[3]),
        .out_busy(busy[3]));

    // Record every valid cycle and overrun pulse of each receiver.
    initial begin
        for (int k = 0; k < 4; k++) begin
            vcnt[k] = 0; ocnt[k] = 0; cap_d[k] = 8'h00;
            cap_pe[k] = 1'b0; cap_fe[k] = 1'b0; cap_bk[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (valid[k] === 1'b1) begin
                    vcnt[k]   = vcnt[k] + 1;
                    cap_d[k]  = dout[k];
                    cap_pe[k] = perr[k];
                    cap_fe[k] = ferr[k];
                    cap_bk[k] = brk[k];
                end
                if (ovr[k] === 1'b1) ocnt[k] = ocnt[k] + 1;
            end
        end
    end

    task automatic drive(input int sel, input logic v);
        case (sel)
            0: line_a = v;
            1: line_p = v;
            2: line_s2 = v;
            default: line_a = v;
        endcase
    endtask

    // Send n bits LSB first (start bit included), 32 clk each, then idle high.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            drive(sel, bits[i]);
            repeat (32) @(negedge clk);
        end
        drive(sel, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; ready = 1'b1;
        line_a = 1'b1; line_p = 1'b1; line_s2 = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (valid[0] !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid[0]); end
        tests_run++; if (dout[0] !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", dout[0]); end
        tests_run++; if (ferr[0] !== 1'b0 || perr[0] !== 1'b0 || brk[0] !== 1'b0) begin
            fails++; $display("FAIL reset_flags got pe=%b fe=%b bk=%b want 0", perr[0], ferr[0], brk[0]); end
        tests_run++; if (ovr[0] !== 1'b0) begin fails++; $display("FAIL reset_ovr got %b want 0", ovr[0]); end
        tests_run++; if (busy[0] !== 1'b0 || busy[3] !== 1'b0) begin
            fails++; $display("FAIL reset_busy got %b/%b want 0", busy[0], busy[3]); end
    endtask

    task automatic test_8n1;
        int v0, o0;
        v0 = vcnt[0]; o0 = ocnt[0];
        send_bits(0, {1'b1, 8'hA5, 1'b0}, 10);
        repeat (10) @(negedge clk);
        tests_run++; if (vcnt[0] - v0 !== 1) begin fails++; $display("FAIL 8n1_valid_cycles got %0d want 1", vcnt[0] - v0); end
        tests_run++; if (cap_d[0] !== 8'hA5) begin fails++; $display("FAIL 8n1_data got %h want a5", cap_d[0]); end
        tests_run++; if (cap_pe[0] !== 1'b0 || cap_fe[0] !== 1'b0 || cap_bk[0] !== 1'b0) begin
            fails++; $display("FAIL 8n1_flags got pe=%b fe=%b bk=%b want 0", cap_pe[0], cap_fe[0], cap_bk[0]); end
        tests_run++; if (ocnt[0] - o0 !== 0) begin fails++; $display("FAIL 8n1_ovr got %0d want 0", ocnt[0] - o0); end
        tests_run++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL 8n1_busy got %b want 0", busy[0]); end
    endtask

    task automatic test_parity;
        int v1, v2;
        v1 = vcnt[1]; v2 = vcnt[2];
        send_bits(1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
        repeat (10) @(negedge clk);
        tests_run++; if (vcnt[1] - v1 !== 1 || cap_d[1] !== 8'h07) begin
            fails++; $display("FAIL even_data got %h (%0d words) want 07 (1)", cap_d[1], vcnt[1] - v1); end
        tests_run++; if (cap_pe[1] !== 1'b1) begin fails++; $display("FAIL even_parity_err got %b want 1", cap_pe[1]); end
        tests_run++; if (vcnt[2] - v2 !== 1 || cap_d[2] !== 8'h07) begin
            fails++; $display("FAIL odd_data got %h (%0d words) want 07 (1)", cap_d[2], vcnt[2] - v2); end
        tests_run++; if (cap_pe[2] !== 1'b0) begin fails++; $display("FAIL odd_parity_err got %b want 0", cap_pe[2]); end
        tests_run++; if (cap_fe[1] !== 1'b0 || cap_fe[2] !== 1'b0) begin
            fails++; $display("FAIL parity_frame_err got %b/%b want 0", cap_fe[1], cap_fe[2]); end
    endtask

    task automatic test_frame_err;
        int v0;
        v0 = vcnt[0];
        send_bits(0, {1'b0, 8'h3C, 1'b0}, 10);
        repeat (10) @(negedge clk);
        tests_run++; if (vcnt[0] - v0 !== 1 || cap_d[0] !== 8'h3C) begin
            fails++; $display("FAIL frame_data got %h (%0d words) want 3c (1)", cap_d[0], vcnt[0] - v0); end
        tests_run++; if (cap_fe[0] !== 1'b1) begin fails++; $display("FAIL frame_err got %b want 1", cap_fe[0]); end
        tests_run++; if (cap_bk[0] !== 1'b0) begin fails++; $display("FAIL frame_break got %b want 0", cap_bk[0]); end
    endtask

    task automatic test_break;
        int v0;
        v0 = vcnt[0];
        line_a = 1'b0;
        repeat (395) @(negedge clk);
        tests_run++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL break_busy_low got %b want 1", busy[0]); end
        tests_run++; if (vcnt[0] - v0 !== 1) begin fails++; $display("FAIL break_words_low got %0d want 1", vcnt[0] - v0); end
        repeat (5) @(negedge clk);
        line_a = 1'b1;
        repeat (40) @(negedge clk);
        tests_run++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL break_busy_high got %b want 0", busy[0]); end
        tests_run++; if (vcnt[0] - v0 !== 1) begin fails++; $display("FAIL break_words got %0d want 1", vcnt[0] - v0); end
        tests_run++; if (cap_d[0] !== 8'h00 || cap_fe[0] !== 1'b1 || cap_bk[0] !== 1'b1) begin
            fails++; $display("FAIL break_flags got d=%h fe=%b bk=%b want 00 1 1", cap_d[0], cap_fe[0], cap_bk[0]); end
    endtask

    task automatic test_glitch;
        int v0;
        v0 = vcnt[0];
        line_a = 1'b0;
        repeat (6) @(negedge clk);
        line_a = 1'b1;
        repeat (40) @(negedge clk);
        tests_run++; if (vcnt[0] - v0 !== 0) begin fails++; $display("FAIL glitch_words got %0d want 0", vcnt[0] - v0); end
        tests_run++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL glitch_busy got %b want 0", busy[0]); end
        send_bits(0, {1'b1, 8'h81, 1'b0}, 10);
        repeat (10) @(negedge clk);
        tests_run++; if (vcnt[0] - v0 !== 1 || cap_d[0] !== 8'h81 || cap_fe[0] !== 1'b0) begin
            fails++; $display("FAIL glitch_next got %h fe=%b (%0d words) want 81 0 (1)", cap_d[0], cap_fe[0], vcnt[0] - v0); end
    endtask

    task automatic test_back_to_back;
        int o0;
        o0 = ocnt[0];
        ready = 1'b0;
        send_bits(0, {1'b1, 8'h11, 1'b0}, 10);
        repeat (10) @(negedge clk);
        tests_run++; if (valid[0] !== 1'b1 || dout[0] !== 8'h11) begin
            fails++; $display("FAIL b2b_first got v=%b d=%h want 1 11", valid[0], dout[0]); end
        send_bits(0, {1'b1, 8'h22, 1'b0}, 10);
        repeat (10) @(negedge clk);
        tests_run++; if (dout[0] !== 8'h11 || valid[0] !== 1'b1) begin
            fails++; $display("FAIL b2b_kept got v=%b d=%h want 1 11", valid[0], dout[0]); end
        tests_run++; if (ocnt[0] - o0 !== 1) begin fails++; $display("FAIL b2b_overrun got %0d want 1", ocnt[0] - o0); end
        ready = 1'b1;
        @(negedge clk);
        tests_run++; if (valid[0] !== 1'b0) begin fails++; $display("FAIL b2b_drop got %b want 0", valid[0]); end
    endtask

    task automatic test_enable;
        ready = 1'b0;
        send_bits(0, {1'b1, 8'h33, 1'b0}, 10);
        repeat (10) @(negedge clk);
        en = 1'b0;
        ready = 1'b1;
        repeat (5) @(negedge clk);
        tests_run++; if (valid[0] !== 1'b1 || dout[0] !== 8'h33) begin
            fails++; $display("FAIL en_freeze got v=%b d=%h want 1 33", valid[0], dout[0]); end
        en = 1'b1;
        @(negedge clk);
        tests_run++; if (valid[0] !== 1'b0) begin fails++; $display("FAIL en_resume got %b want 0", valid[0]); end
    endtask

    task automatic test_reset_mid;
        int v0;
        send_bits(0, {1'b0, 1'b1, 1'b0, 1'b0}, 4);
        line_a = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        line_a = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (busy[0] !== 1'b0 || valid[0] !== 1'b0) begin
            fails++; $display("FAIL rstmid_idle got busy=%b v=%b want 0 0", busy[0], valid[0]); end
        v0 = vcnt[0];
        repeat (10) @(negedge clk);
        send_bits(0, {1'b1, 8'h5A, 1'b0}, 10);
        repeat (10) @(negedge clk);
        tests_run++; if (vcnt[0] - v0 !== 1 || cap_d[0] !== 8'h5A) begin
            fails++; $display("FAIL rstmid_data got %h (%0d words) want 5a (1)", cap_d[0], vcnt[0] - v0); end
    endtask

    task automatic test_stop2;
        int v3;
        v3 = vcnt[3];
        send_bits(2, {2'b11, 8'h96, 1'b0}, 11);
        repeat (10) @(negedge clk);
        tests_run++; if (vcnt[3] - v3 !== 1 || cap_d[3] !== 8'h96 || cap_fe[3] !== 1'b0) begin
            fails++; $display("FAIL stop2_good got %h fe=%b (%0d words) want 96 0 (1)", cap_d[3], cap_fe[3], vcnt[3] - v3); end
        send_bits(2, {2'b01, 8'h96, 1'b0}, 11);
        repeat (10) @(negedge clk);
        tests_run++; if (vcnt[3] - v3 !== 2 || cap_fe[3] !== 1'b1 || cap_bk[3] !== 1'b0) begin
            fails++; $display("FAIL stop2_bad got fe=%b bk=%b (%0d words) want 1 0 (2)", cap_fe[3], cap_bk[3], vcnt[3] - v3); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_break();
        test_glitch();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_stop2();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
